// File: rtl/bus_pkg.sv
// Shared defaults and encodings for the bus word serializer.
package bus_pkg;

    localparam int unsigned BUS_SIZE_DEF   = 16;
    localparam int unsigned WORD_SIZE_DEF  = 4;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned CNT_WIDTH_DEF  = 8;
    localparam int unsigned STATE_W        = 5;

    localparam logic [STATE_W-1:0] VALID_STATE_MASK_DEF = 5'b00100;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous packet FIFO; exposes the head and the entry behind it so the
// serializer can preload the next packet in the same cycle it pops the head.
module pkt_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [DATA_W-1:0] second,
    output logic              full,
    output logic              empty,
    output logic              multi
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       occ;
    logic [AW-1:0]     rd_next;

    assign occ     = wr_ptr - rd_ptr;
    assign rd_next = rd_ptr[AW-1:0] + AW'(1);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign multi   = (occ > (AW+1)'(1));
    assign head    = mem[rd_ptr[AW-1:0]];
    assign second  = mem[rd_next];

    // Storage needs no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/bus_word_serializer.sv
// Captures qualified bus packets into a FIFO and streams them out MSB word
// first over valid/ready, with saturating accept/drop statistics.
module bus_word_serializer
    import bus_pkg::*;
#(
    parameter int unsigned         BUS_SIZE         = BUS_SIZE_DEF,
    parameter int unsigned         WORD_SIZE        = WORD_SIZE_DEF,
    parameter int unsigned         WORD_NUM         = BUS_SIZE / WORD_SIZE,
    parameter int unsigned         FIFO_DEPTH       = FIFO_DEPTH_DEF,
    parameter logic [STATE_W-1:0]  VALID_STATE_MASK = VALID_STATE_MASK_DEF,
    parameter int unsigned         CNT_WIDTH        = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_SIZE-1:0]  bus_data_in,
    input  logic                 error,
    input  logic [STATE_W-1:0]   state,
    output logic [WORD_SIZE-1:0] word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 sop,
    output logic                 eop,
    output logic                 fifo_full,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    localparam int unsigned    IDX_W    = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_NUM - 1);

    ser_state_t           ser_q, ser_d;
    logic [IDX_W-1:0]     idx_q, idx_d, idx_inc;
    logic [WORD_SIZE-1:0] word_d;
    logic                 valid_d, sop_d, eop_d;

    logic                 accept, xfer, pop, full_eff, push, drop;
    logic [BUS_SIZE-1:0]  head, second, next_pkt;
    logic                 f_full, f_empty, f_multi;

    function automatic logic [WORD_SIZE-1:0] pick(input logic [BUS_SIZE-1:0] pkt,
                                                  input logic [IDX_W-1:0]    i);
        return WORD_SIZE'(pkt >> (WORD_SIZE * (WORD_NUM - 1 - 32'(i))));
    endfunction

    assign accept   = (|(state & VALID_STATE_MASK)) && !error;
    assign xfer     = word_valid && word_ready;
    assign pop      = xfer && (idx_q == LAST_IDX);
    assign full_eff = f_full && !pop;
    assign push     = accept && !full_eff;
    assign drop     = (accept && full_eff) || (!accept && (error || (state != '0)));
    assign idx_inc  = idx_q + IDX_W'(1);
    // With a single entry left the packet following the head is the one being pushed now.
    assign next_pkt = f_multi ? second : bus_data_in;
    assign fifo_full = f_full;

    pkt_fifo #(
        .DATA_W (BUS_SIZE),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus_data_in),
        .pop       (pop),
        .head      (head),
        .second    (second),
        .full      (f_full),
        .empty     (f_empty),
        .multi     (f_multi)
    );

    // Next-state and next-output decode; outputs hold while stalled.
    always_comb begin
        ser_d   = ser_q;
        idx_d   = idx_q;
        valid_d = word_valid;
        word_d  = word_out;
        sop_d   = sop;
        eop_d   = eop;
        case (ser_q)
            IDLE: begin
                if (!f_empty) begin
                    ser_d   = SEND;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    word_d  = pick(head, '0);
                    sop_d   = 1'b1;
                    eop_d   = (WORD_NUM == 1);
                end
            end
            SEND: begin
                if (pop) begin
                    idx_d = '0;
                    if (f_multi || push) begin
                        ser_d   = SEND;
                        valid_d = 1'b1;
                        word_d  = pick(next_pkt, '0);
                        sop_d   = 1'b1;
                        eop_d   = (WORD_NUM == 1);
                    end else begin
                        ser_d   = IDLE;
                        valid_d = 1'b0;
                        word_d  = '0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                    end
                end else if (xfer) begin
                    idx_d  = idx_inc;
                    word_d = pick(head, idx_inc);
                    sop_d  = 1'b0;
                    eop_d  = (idx_inc == LAST_IDX);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ser_q      <= IDLE;
            idx_q      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            sop        <= 1'b0;
            eop        <= 1'b0;
            pkt_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            ser_q      <= ser_d;
            idx_q      <= idx_d;
            word_out   <= word_d;
            word_valid <= valid_d;
            sop        <= sop_d;
            eop        <= eop_d;
            if (push && (pkt_cnt != '1)) begin
                pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_word_serializer.sv
// Scoreboard bench for bus_word_serializer: packet-level reference model
// feeds an expected-word queue that a negedge monitor checks against the DUT.
module tb_bus_word_serializer;

    localparam int       DEPTH = 4;
    localparam int       NWORD = 4;
    localparam logic [4:0] MASK = 5'b00100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] bus_data_in = '0;
    logic        error = 1'b0;
    logic [4:0]  state = '0;
    logic [3:0]  word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        sop;
    logic        eop;
    logic        fifo_full;
    logic [7:0]  pkt_cnt;
    logic [7:0]  drop_cnt;

    typedef struct {
        logic [3:0] w;
        bit         sop;
        bit         eop;
    } exp_t;

    exp_t       exp_q[$];
    int         occ = 0;
    logic [7:0] m_pkt = '0;
    logic [7:0] m_drop = '0;
    int         n_cmp = 0;
    int         n_mis = 0;

    bus_word_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .bus_data_in (bus_data_in),
        .error       (error),
        .state       (state),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .sop         (sop),
        .eop         (eop),
        .fifo_full   (fifo_full),
        .pkt_cnt     (pkt_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor + reference model, evaluated between edges with inputs stable.
    always @(negedge clk) begin
        bit         pop_last;
        bit         acc;
        logic [15:0] d;
        exp_t       e;
        pop_last = 1'b0;
        if (!reset) begin
            exp_q.delete();
            occ    = 0;
            m_pkt  = '0;
            m_drop = '0;
        end else begin
            check("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            check("fifo_full", 32'(fifo_full), 32'(occ == DEPTH));
            if (word_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(word_valid), 32'(0));
                end else begin
                    check("word_out", 32'(word_out), 32'(exp_q[0].w));
                    check("sop", 32'(sop), 32'(exp_q[0].sop));
                    check("eop", 32'(eop), 32'(exp_q[0].eop));
                    if (word_ready) begin
                        pop_last = exp_q[0].eop;
                        void'(exp_q.pop_front());
                    end
                end
            end
            acc = ((state & MASK) != 5'd0) && !error;
            if (acc) begin
                if (occ == DEPTH && !pop_last) begin
                    if (m_drop != 8'hFF) m_drop++;
                end else begin
                    occ++;
                    if (m_pkt != 8'hFF) m_pkt++;
                    d = bus_data_in;
                    for (int k = 0; k < NWORD; k++) begin
                        e.w   = d[15 - 4*k -: 4];
                        e.sop = (k == 0);
                        e.eop = (k == NWORD - 1);
                        exp_q.push_back(e);
                    end
                end
            end else if (error || state != 5'd0) begin
                if (m_drop != 8'hFF) m_drop++;
            end
            if (pop_last) occ--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic [4:0] s, input logic e);
        bus_data_in = d;
        state       = s;
        error       = e;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        word_ready = 1'b1;
        drive(16'h0, 5'd0, 1'b0);
        while ((exp_q.size() != 0 || word_valid) && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_valid", 32'(word_valid), 32'(0));
        check("rst_full", 32'(fifo_full), 32'(0));
        check("rst_pkt", 32'(pkt_cnt), 32'(0));

        // Single packet, latency and throughput
        word_ready = 1'b1;
        drive(16'hA5C3, 5'b00100, 1'b0);
        tick();
        drive(16'h0, 5'd0, 1'b0);
        check("lat_not_yet", 32'(word_valid), 32'(0));
        tick();
        check("w0_valid", 32'(word_valid), 32'(1));
        check("w0_data", 32'(word_out), 32'hA);
        check("w0_sop", 32'(sop), 32'(1));
        tick();
        check("w1_data", 32'(word_out), 32'h5);
        tick();
        check("w2_data", 32'(word_out), 32'hC);
        tick();
        check("w3_data", 32'(word_out), 32'h3);
        check("w3_eop", 32'(eop), 32'(1));
        tick();
        check("single_done", 32'(word_valid), 32'(0));
        check("single_pkt", 32'(pkt_cnt), 32'(1));

        // Backpressure with ready pattern 1,0,0,1
        drive(16'h1234, 5'b00100, 1'b0);
        tick();
        drive(16'hBEEF, 5'b10110, 1'b0);
        tick();
        drive(16'h0, 5'd0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            word_ready = (i % 4 == 1 || i % 4 == 2) ? 1'b0 : 1'b1;
            tick();
        end
        drain(40);

        // Overflow: 5 packets with ready low
        word_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(16'($urandom), 5'b00100, 1'b0);
            tick();
            if (i == 3) check("ovf_full", 32'(fifo_full), 32'(1));
        end
        drive(16'h0, 5'd0, 1'b0);
        check("ovf_drop", 32'(drop_cnt), 32'(1));
        check("ovf_pkt", 32'(pkt_cnt), 32'(7));
        drain(100);

        // Drops from error and non-qualifying state
        drive(16'($urandom), 5'b00100, 1'b1);
        tick();
        drive(16'($urandom), 5'b01000, 1'b0);
        tick();
        drive(16'h0, 5'd0, 1'b0);
        tick();
        check("drop_two", 32'(drop_cnt), 32'(3));
        check("drop_noout", 32'(word_valid), 32'(0));
        tick();
        check("idle_nocount", 32'(drop_cnt), 32'(3));

        // Full FIFO with push on final-word pop
        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(16'($urandom), 5'b00100, 1'b0);
            tick();
        end
        drive(16'h0, 5'd0, 1'b0);
        check("sim_full", 32'(fifo_full), 32'(1));
        word_ready = 1'b1;
        n = 0;
        while (!(word_valid && eop) && n < 10) begin
            tick();
            n++;
        end
        check("sim_reach_eop", 32'(word_valid && eop), 32'(1));
        drive(16'h5A69, 5'b00100, 1'b0);
        tick();
        drive(16'h0, 5'd0, 1'b0);
        check("sim_drop", 32'(drop_cnt), 32'(3));
        check("sim_pkt", 32'(pkt_cnt), 32'(12));
        check("sim_still_full", 32'(fifo_full), 32'(1));
        drain(100);

        // Reset mid-packet
        drive(16'hC0DE, 5'b00100, 1'b0);
        tick();
        drive(16'h0, 5'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(word_valid), 32'(0));
        check("mid_rst_word", 32'(word_out), 32'(0));
        check("mid_rst_sop_eop", 32'({sop, eop}), 32'(0));
        check("mid_rst_full", 32'(fifo_full), 32'(0));
        check("mid_rst_cnts", 32'({pkt_cnt, drop_cnt}), 32'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();
        drive(16'h7E81, 5'b00100, 1'b0);
        tick();
        drain(20);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            word_ready = ($urandom % 4) != 0;
            case ($urandom % 4)
                0: drive(16'($urandom), 5'd0, 1'b0);
                1: drive(16'($urandom), 5'($urandom), 1'b0);
                default: drive(16'($urandom), 5'b00100 | 5'($urandom), ($urandom % 8) == 0);
            endcase
            tick();
        end
        drain(200);

        // Saturation: 300 paced accepted packets
        for (int i = 0; i < 300; i++) begin
            word_ready = 1'b1;
            drive(16'($urandom), 5'b00100, 1'b0);
            tick();
            drive(16'h0, 5'd0, 1'b0);
            repeat (3) tick();
        end
        drain(40);
        check("pkt_sat", 32'(pkt_cnt), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
